// File: rtl/key_event_ctrl.sv
// Debounces the keypad level vector and turns newly pressed keys into 4-bit
// codes that are queued in a small first-word-fall-through FIFO.
module key_event_ctrl #(
  parameter int SAMPLE_DIV = 1000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keys_i,
  output logic [3:0]  evt_code_o,
  output logic        evt_valid_o,
  input  logic        evt_ready_i,
  output logic        overflow_o,
  input  logic        clr_ovf_i,
  output logic        any_pressed_o,
  output logic        busy_o
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, ENCODE} state_t;

  state_t        state_q;
  logic [TW-1:0] tcnt_q;
  logic [15:0]   cand_q, cand_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [15:0]   stable_q;
  logic [15:0]   pending_q, pendingClr;
  logic [15:0]   newPress;
  logic          accept;
  logic          tick;
  logic [3:0]    lowIdx;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          push, pop, full, pushOk, drop;

  assign tick = (tcnt_q == TW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) tcnt_q <= '0;
    else if (tick) tcnt_q <= '0;
    else tcnt_q <= tcnt_q + TW'(1);
  end

  // Next candidate/stability count as if a sample were taken this cycle.
  always_comb begin
    cand_d = cand_q;
    scnt_d = scnt_q;
    if (keys_i != cand_q) begin
      cand_d = keys_i;
      scnt_d = SW'(1);
    end else if (scnt_q != SW'(DEBOUNCE)) begin
      scnt_d = scnt_q + SW'(1);
    end
    accept   = (scnt_d == SW'(DEBOUNCE)) && (cand_d != stable_q);
    newPress = cand_d & ~stable_q;
  end

  always_comb begin
    lowIdx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pending_q[i]) lowIdx = 4'(i);
    end
    pendingClr = pending_q & ~(16'd1 << lowIdx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      scnt_q    <= '0;
      stable_q  <= '0;
      pending_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            cand_q <= cand_d;
            scnt_q <= scnt_d;
            if (accept) begin
              stable_q  <= cand_d;
              pending_q <= newPress;
              if (|newPress) state_q <= ENCODE;
            end
          end
        end
        ENCODE: begin
          pending_q <= pendingClr;
          if (pendingClr == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push   = (state_q == ENCODE);
  assign pop    = (count_q != '0) && evt_ready_i;
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign pushOk = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (pushOk) begin
        mem_q[wptr_q] <= lowIdx;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      if (pushOk && !pop) count_q <= count_q + CW'(1);
      else if (!pushOk && pop) count_q <= count_q - CW'(1);
      if (drop) ovf_q <= 1'b1;
      else if (clr_ovf_i) ovf_q <= 1'b0;
    end
  end

  assign evt_code_o    = mem_q[rptr_q];
  assign evt_valid_o   = (count_q != '0);
  assign overflow_o    = ovf_q;
  assign any_pressed_o = |stable_q;
  assign busy_o        = (state_q == ENCODE);

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: directed phase table, reset
// sequence and randomized traffic against a queue-based reference model.
module tb_key_event_ctrl;

  localparam int SD    = 20;
  localparam int DB    = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keysR;
  logic        readyR, clrR;
  logic [3:0]  evtCode;
  logic        evtValid, overflow, anyPressed, busy;

  int vectors = 0;
  int miscompares = 0;

  key_event_ctrl #(.SAMPLE_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .keys_i(keysR), .evt_code_o(evtCode),
    .evt_valid_o(evtValid), .evt_ready_i(readyR), .overflow_o(overflow),
    .clr_ovf_i(clrR), .any_pressed_o(anyPressed), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference model: sample history, pending code list and FIFO contents.
  logic [15:0] mStable;
  logic [15:0] mHist[$];
  int          mPend[$];
  logic [3:0]  mFifo[$];
  bit          mOvf;
  int          mCyc;

  task automatic modelEdge();
    bit tickNow, doPop, allSame;
    logic [15:0] newp;
    int code;
    if (rst) begin
      mStable = '0; mHist.delete(); mPend.delete(); mFifo.delete();
      mOvf = 0; mCyc = 0;
      return;
    end
    tickNow = (mCyc % SD) == SD - 1;
    mCyc++;
    doPop = (mFifo.size() != 0) && readyR;
    if (doPop) void'(mFifo.pop_front());
    if (mPend.size() != 0) begin
      code = mPend.pop_front();
      if (mFifo.size() < DEPTH) begin
        mFifo.push_back(4'(code));
        if (clrR) mOvf = 0;
      end else mOvf = 1;
    end else begin
      if (clrR) mOvf = 0;
      if (tickNow) begin
        mHist.push_back(keysR);
        while (mHist.size() > DB) void'(mHist.pop_front());
        allSame = (mHist.size() == DB);
        foreach (mHist[i]) if (mHist[i] != mHist[0]) allSame = 0;
        if (allSame && mHist[0] != mStable) begin
          newp = mHist[0] & ~mStable;
          mStable = mHist[0];
          for (int i = 0; i < 16; i++) if (newp[i]) mPend.push_back(i);
        end
      end
    end
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("model.valid", evtValid, mFifo.size() != 0);
    if (mFifo.size() != 0) cmp("model.code", evtCode, mFifo[0]);
    cmp("model.busy", busy, mPend.size() != 0);
    cmp("model.any", anyPressed, mStable != 0);
    cmp("model.ovf", overflow, mOvf);
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] keys;
    bit ready, clr;
    int cycles;
    bit expValid;
    logic [3:0] expCode;
    bit expOvf, expAny, expBusy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] k, bit r, bit c, int n, bit v,
                              logic [3:0] code, bit o, bit a, bit b);
    vec_t t;
    t.keys = k; t.ready = r; t.clr = c; t.cycles = n; t.expValid = v;
    t.expCode = code; t.expOvf = o; t.expAny = a; t.expBusy = b;
    return t;
  endfunction

  task automatic applyStimulus(vec_t t, int idx);
    string tag;
    keysR = t.keys; readyR = t.ready; clrR = t.clr;
    for (int c = 0; c < t.cycles; c++) step();
    clrR = 0;
    tag = $sformatf("tbl%0d", idx);
    cmp({tag, ".valid"}, evtValid, t.expValid);
    if (t.expValid) cmp({tag, ".code"}, evtCode, t.expCode);
    cmp({tag, ".ovf"}, overflow, t.expOvf);
    cmp({tag, ".any"}, anyPressed, t.expAny);
    cmp({tag, ".busy"}, busy, t.expBusy);
  endtask

  initial begin
    int n;
    int hold;
    int sel;
    logic [31:0] r;
    rst = 1; keysR = 0; readyR = 0; clrR = 0;
    mStable = 0; mOvf = 0; mCyc = 0;
    repeat (3) step();
    cmp("reset.valid", evtValid, 0);
    cmp("reset.code", evtCode, 0);
    cmp("reset.ovf", overflow, 0);
    cmp("reset.any", anyPressed, 0);
    cmp("reset.busy", busy, 0);
    rst = 0;

    // single press, pop, hold, release, glitch
    tbl.push_back(mk(16'h0020, 0, 0, 60, 0, 0, 0, 1, 1));
    tbl.push_back(mk(16'h0020, 0, 0, 1, 1, 5, 0, 1, 0));
    tbl.push_back(mk(16'h0020, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(16'h0020, 1, 0, 100, 0, 0, 0, 1, 0));
    tbl.push_back(mk(16'h0000, 1, 0, 80, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h0020, 1, 0, 20, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h0000, 1, 0, 80, 0, 0, 0, 0, 0));
    // multi-key 0x8009
    tbl.push_back(mk(16'h8009, 0, 0, 58, 0, 0, 0, 1, 1));
    tbl.push_back(mk(16'h8009, 0, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(16'h8009, 0, 0, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(16'h8009, 1, 0, 1, 1, 3, 0, 1, 0));
    tbl.push_back(mk(16'h8009, 1, 0, 1, 1, 15, 0, 1, 0));
    tbl.push_back(mk(16'h8009, 1, 0, 1, 0, 0, 0, 1, 0));
    // overflow build-up
    tbl.push_back(mk(16'h0000, 0, 0, 74, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h0001, 0, 0, 61, 1, 0, 0, 1, 0));
    tbl.push_back(mk(16'h0003, 0, 0, 60, 1, 0, 0, 1, 0));
    tbl.push_back(mk(16'h0007, 0, 0, 60, 1, 0, 0, 1, 0));
    tbl.push_back(mk(16'h000F, 0, 0, 60, 1, 0, 0, 1, 0));
    tbl.push_back(mk(16'h001F, 0, 0, 60, 1, 0, 1, 1, 0));
    tbl.push_back(mk(16'h001F, 0, 1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(16'h001F, 1, 0, 1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(16'h001F, 1, 0, 1, 1, 2, 0, 1, 0));
    tbl.push_back(mk(16'h001F, 1, 0, 1, 1, 3, 0, 1, 0));
    tbl.push_back(mk(16'h001F, 1, 0, 1, 0, 0, 0, 1, 0));
    // full FIFO with simultaneous pop and push
    tbl.push_back(mk(16'h0000, 0, 0, 55, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h0001, 0, 0, 60, 1, 0, 0, 1, 0));
    tbl.push_back(mk(16'h0003, 0, 0, 60, 1, 0, 0, 1, 0));
    tbl.push_back(mk(16'h0007, 0, 0, 60, 1, 0, 0, 1, 0));
    tbl.push_back(mk(16'h000F, 0, 0, 60, 1, 0, 0, 1, 0));
    tbl.push_back(mk(16'h001F, 0, 0, 59, 1, 0, 0, 1, 1));
    tbl.push_back(mk(16'h001F, 1, 0, 1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(16'h001F, 0, 0, 5, 1, 1, 0, 1, 0));
    tbl.push_back(mk(16'h001F, 1, 0, 4, 0, 0, 0, 1, 0));
    tbl.push_back(mk(16'h0000, 1, 0, 70, 0, 0, 0, 0, 0));

    foreach (tbl[i]) applyStimulus(tbl[i], i);

    // reset in the middle of an encode burst
    keysR = 16'h000F; readyR = 0;
    n = 0;
    while (!busy && n < 200) begin step(); n++; end
    cmp("rstSeq.busyReached", busy, 1);
    repeat (2) step();
    cmp("rstSeq.queued", evtValid, 1);
    rst = 1;
    step();
    cmp("rstSeq.valid", evtValid, 0);
    cmp("rstSeq.busy", busy, 0);
    cmp("rstSeq.ovf", overflow, 0);
    cmp("rstSeq.any", anyPressed, 0);
    rst = 0;
    n = 0;
    while (!evtValid && n < 200) begin step(); n++; end
    cmp("rstSeq.freshValid", evtValid, 1);
    cmp("rstSeq.freshCode", evtCode, 0);
    cmp("rstSeq.latency", n, 61);

    // randomized traffic
    for (int it = 0; it < 70; it++) begin
      r = $urandom();
      sel = $urandom_range(0, 3);
      if (sel == 0) keysR = '0;
      else if (sel == 1) keysR = 16'(r) & 16'($urandom()) & 16'($urandom());
      else if (sel == 2) keysR = keysR ^ (16'd1 << $urandom_range(0, 15));
      else keysR = 16'(r);
      hold = $urandom_range(5, 90);
      for (int c = 0; c < hold; c++) begin
        readyR = ($urandom_range(0, 3) != 0);
        clrR   = ($urandom_range(0, 15) == 0);
        rst    = ($urandom_range(0, 999) == 0);
        step();
      end
      rst = 0; clrR = 0;
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
